// File: rtl/servo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : servo_sequencer
// Brief    : Bit-serial instruction receiver, sort-sequence FSM with sensor
//            timeouts / conflict fault, and N_CH shared-frame servo PWM.
// Revision : 1.0 - initial release
// ============================================================================
module servo_sequencer #(
    parameter int               N_CH          = 2,
    parameter int               POS_W         = 8,
    parameter int               PERIOD_CYC    = 1500000,
    parameter int               MIN_PULSE_CYC = 50000,
    parameter int               STEP_CYC      = 196,
    parameter int               TIMEOUT_CYC   = 150000000,
    parameter logic [POS_W-1:0] TRACK_FWD     = '1,
    parameter logic [POS_W-1:0] TRACK_BACK    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mbedCommand,
    input  logic            confirm,
    input  logic            correct,
    input  logic            extended,
    input  logic            retracted,
    output logic            waiting,
    output logic            busy,
    output logic            fault,
    output logic [N_CH-1:0] servo_out
);

    localparam int     c_CH_W      = (N_CH > 2) ? $clog2(N_CH) : 1;
    localparam int     c_INSTR_W   = 2 + c_CH_W + POS_W;
    localparam int     c_BIT_W     = $clog2(c_INSTR_W + 1);
    localparam int     c_TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam longint c_MAX_WIDTH = longint'(MIN_PULSE_CYC)
                                   + ((longint'(1) << POS_W) - 1) * longint'(STEP_CYC);
    localparam int     c_WID_W     = $clog2(c_MAX_WIDTH + 1);
    localparam int     c_FRM_W     = $clog2(PERIOD_CYC);
    localparam int     c_CMP_W     = (c_WID_W > c_FRM_W) ? c_WID_W : c_FRM_W;

    localparam logic [1:0] c_MODE_DIRECT  = 2'b00;
    localparam logic [1:0] c_MODE_SORT    = 2'b01;
    localparam logic [1:0] c_MODE_DISABLE = 2'b10;
    localparam logic [1:0] c_MODE_CLEAR   = 2'b11;

    localparam logic [N_CH-1:0] c_EN_CH0 = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [N_CH-1:0] c_EN_CH1 = c_EN_CH0 << 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_SPIN   = 3'd2,
        ST_PUSH   = 3'd3,
        ST_PULL   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_fault;
    logic [N_CH-1:0]       r_en;
    logic [POS_W-1:0]      r_pos [N_CH];
    logic [c_TO_W-1:0]     r_wait_cnt;

    logic [1:0]            r_cmd_sync;
    logic [1:0]            r_conf_sync;
    logic [1:0]            r_corr_sync;
    logic [1:0]            r_ext_sync;
    logic [1:0]            r_ret_sync;
    logic                  r_conf_prev;

    logic [c_INSTR_W-1:0]  r_shift;
    logic [c_BIT_W-1:0]    r_bitcnt;
    logic [c_TO_W-1:0]     r_gap_cnt;
    logic [c_CMP_W-1:0]    r_frame;

    logic                  w_cmd;
    logic                  w_conf_edge;
    logic                  w_corr;
    logic                  w_ext;
    logic                  w_ret;
    logic                  w_conflict;
    logic                  w_rx_active;
    logic                  w_word_rdy;
    logic [1:0]            w_mode;
    logic [c_CH_W-1:0]     w_ch;
    logic [POS_W-1:0]      w_pos;
    logic                  w_bad_ch;
    logic                  w_wait_expired;
    logic                  w_frame_start;

    // Two-flop synchronisers for every pin coming from the mbed / sensors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_sync  <= '0;
            r_conf_sync <= '0;
            r_corr_sync <= '0;
            r_ext_sync  <= '0;
            r_ret_sync  <= '0;
            r_conf_prev <= 1'b0;
        end else begin
            r_cmd_sync  <= {r_cmd_sync[0],  mbedCommand};
            r_conf_sync <= {r_conf_sync[0], confirm};
            r_corr_sync <= {r_corr_sync[0], correct};
            r_ext_sync  <= {r_ext_sync[0],  extended};
            r_ret_sync  <= {r_ret_sync[0],  retracted};
            r_conf_prev <= r_conf_sync[1];
        end
    end

    assign w_cmd       = r_cmd_sync[1];
    assign w_conf_edge = r_conf_sync[1] & ~r_conf_prev;
    assign w_corr      = r_corr_sync[1];
    assign w_ext       = r_ext_sync[1];
    assign w_ret       = r_ret_sync[1];
    assign w_conflict  = w_ext & w_ret;

    assign w_rx_active = (r_state == ST_IDLE) || (r_state == ST_FAULT);
    assign w_word_rdy  = (r_bitcnt == c_BIT_W'(c_INSTR_W));
    assign w_mode      = r_shift[c_INSTR_W-1 -: 2];
    assign w_ch        = r_shift[POS_W +: c_CH_W];
    assign w_pos       = r_shift[POS_W-1:0];

    assign w_wait_expired = (r_wait_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    // Channel field can only name a missing channel when N_CH is not a power of two
    generate
        if ((1 << c_CH_W) > N_CH) begin : g_ch_check
            localparam logic [c_CH_W:0] c_N_CH_EXT = N_CH[c_CH_W:0];
            assign w_bad_ch = ({1'b0, w_ch} >= c_N_CH_EXT);
        end else begin : g_ch_full
            assign w_bad_ch = 1'b0;
        end
    endgenerate

    // Serial receiver: shifts on confirm edges in IDLE/FAULT, drops stale partial words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_gap_cnt <= '0;
        end else if (!w_rx_active) begin
            r_gap_cnt <= '0;
        end else if (w_word_rdy) begin
            r_bitcnt  <= '0;
            r_gap_cnt <= '0;
        end else if (w_conf_edge) begin
            r_shift   <= {r_shift[c_INSTR_W-2:0], w_cmd};
            r_bitcnt  <= r_bitcnt + 1'b1;
            r_gap_cnt <= '0;
        end else if (r_bitcnt != '0) begin
            if (r_gap_cnt == c_TO_W'(TIMEOUT_CYC - 1)) begin
                r_bitcnt  <= '0;
                r_shift   <= '0;
                r_gap_cnt <= '0;
            end else begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    // Main sequencer: decode, sort sequence with per-wait timeout, fault latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fault    <= 1'b0;
            r_en       <= '0;
            r_wait_cnt <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_pos[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_word_rdy) begin
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (w_mode)
                        c_MODE_DIRECT: begin
                            if (w_bad_ch) begin
                                r_fault <= 1'b1;
                                r_en    <= '0;
                                r_state <= ST_FAULT;
                            end else begin
                                r_pos[w_ch] <= w_pos;
                                r_en[w_ch]  <= 1'b1;
                                r_state     <= ST_IDLE;
                            end
                        end
                        c_MODE_SORT: begin
                            r_en       <= c_EN_CH0;
                            r_pos[0]   <= w_pos;
                            r_wait_cnt <= '0;
                            r_state    <= ST_SPIN;
                        end
                        c_MODE_DISABLE: begin
                            r_en    <= '0;
                            r_state <= ST_IDLE;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
                ST_SPIN: begin
                    if (w_wait_expired) begin
                        r_fault <= 1'b1;
                        r_en    <= '0;
                        r_state <= ST_FAULT;
                    end else if (w_corr) begin
                        r_en       <= c_EN_CH1;
                        r_pos[1]   <= TRACK_FWD;
                        r_wait_cnt <= '0;
                        r_state    <= ST_PUSH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_PUSH: begin
                    if (w_conflict || w_wait_expired) begin
                        r_fault <= 1'b1;
                        r_en    <= '0;
                        r_state <= ST_FAULT;
                    end else if (w_ext) begin
                        r_pos[1]   <= TRACK_BACK;
                        r_wait_cnt <= '0;
                        r_state    <= ST_PULL;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_PULL: begin
                    if (w_conflict || w_wait_expired) begin
                        r_fault <= 1'b1;
                        r_en    <= '0;
                        r_state <= ST_FAULT;
                    end else if (w_ret) begin
                        r_en[1] <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    r_en <= '0;
                    if (w_word_rdy && (w_mode == c_MODE_CLEAR)) begin
                        r_fault <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign waiting = (r_state == ST_IDLE) || (r_state == ST_FAULT);
    assign busy    = (r_state == ST_DECODE) || (r_state == ST_SPIN)
                  || (r_state == ST_PUSH)   || (r_state == ST_PULL);
    assign fault   = r_fault;

    // Shared PWM frame counter, 0..PERIOD_CYC-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame <= '0;
        end else if (r_frame == c_CMP_W'(PERIOD_CYC - 1)) begin
            r_frame <= '0;
        end else begin
            r_frame <= r_frame + 1'b1;
        end
    end

    assign w_frame_start = (r_frame == '0);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [c_CMP_W-1:0] w_width_new;
            logic [c_CMP_W-1:0] w_width_cur;
            logic [c_CMP_W-1:0] r_width;

            assign w_width_new = c_CMP_W'(MIN_PULSE_CYC)
                               + c_CMP_W'(r_pos[gi]) * c_CMP_W'(STEP_CYC);

            // Pulse width is captured once per frame so mid-frame moves never glitch
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_width <= '0;
                end else if (w_frame_start) begin
                    r_width <= w_width_new;
                end
            end

            // During the counter-0 cycle the freshly captured width already applies
            assign w_width_cur   = w_frame_start ? w_width_new : r_width;
            assign servo_out[gi] = r_en[gi] & (r_frame < w_width_cur);
        end
    endgenerate

endmodule
`default_nettype wire
